// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Optional early termination is enabled with SEQ_MUL_EARLY_TERM_EN (see seq_shift_add_multiplier).
package seq_mul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Shift-and-add datapath: accumulator, shifting multiplicand and multiplier registers.
// The controlling FSM issues load (capture operands) and step (one iteration) enables.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] sum_o,
    output logic               mplr_next_zero_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplr_q;

    // Accumulated value including the current iteration's partial product.
    assign sum_o            = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign mplr_next_zero_o = (mplr_q >> 1) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
        end else if (load_i) begin
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_i};
            mplr_q  <= b_i;
        end else if (step_i) begin
            acc_q   <= sum_o;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one multiplier bit per clock, start/busy/done.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_multiplier
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] sum;
    logic               mplr_next_zero;
    logic               last_iter;
    logic               early_exit;
    logic               finish;

    assign load      = start && (state_q != StRun);
    assign step      = (state_q == StRun);
    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign early_exit = mplr_next_zero;
`else
    logic unused_mplr_next_zero;
    assign unused_mplr_next_zero = mplr_next_zero;
    assign early_exit            = 1'b0;
`endif

    assign finish = last_iter || early_exit;

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_i           (load),
        .step_i           (step),
        .a_i              (a),
        .b_i              (b),
        .sum_o            (sum),
        .mplr_next_zero_o (mplr_next_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    count_q <= count_q + CNT_W'(1);
                    if (finish) begin
                        product_q <= sum;
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=4); honours SEQ_MUL_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;

    localparam int unsigned W = 4;

    typedef struct {
        logic [2*W-1:0] prod;
        int unsigned    cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    exp_t           sb[$];
    logic [2*W-1:0] last_prod = '0;
    int unsigned    cyc = 0;
    int unsigned    tests = 0;
    int unsigned    fails = 0;

    seq_shift_add_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int unsigned exp_lat(input logic [W-1:0] y);
        int unsigned l;
`ifdef SEQ_MUL_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < int'(W); i++) if (y[i]) l = i + 1;
`else
        l = W;
`endif
        return l;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] p);
        exp_t e;
        e.prod = p;
        e.cyc  = cyc + 1 + exp_lat(y);
        sb.push_back(e);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb.size()), 0);
    endtask

    // Monitor: pop and compare on every done; otherwise product must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 64'(product), 64'(e.prod));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    last_prod = e.prod;
                end
            end else begin
                check("product_hold", 64'(product), 64'(last_prod));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_product", 64'(product), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 3*3 with busy window and done timing
        issue(4'd3, 4'd3, 8'd9);
        for (int i = 0; i < int'(exp_lat(4'd3)); i++) begin
            check("busy_high", 64'(busy), 1);
            @(negedge clk);
        end
        check("busy_low_at_done", 64'(busy), 0);
        check("done_at_latency", 64'(done), 1);
        wait_done();

        // Exhaustive against a*b
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                issue(W'(x), W'(y), (2*W)'(x * y));
                wait_done();
            end
        end
        repeat (2) @(negedge clk);

        // Max operands, then a start during busy must be ignored
        issue(4'd15, 4'd15, 8'd225);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (8) @(negedge clk);
        check("ignored_start_product", 64'(product), 225);

        // Back-to-back: start held high across the DONE cycle
        begin
            exp_t e;
            int unsigned n;
            e.prod = 8'd30;
            e.cyc  = cyc + 1 + exp_lat(4'd6);
            sb.push_back(e);
            start = 1'b1;
            a     = 4'd5;
            b     = 4'd6;
            @(negedge clk);
            a = 4'd7;
            b = 4'd9;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done_seen", 64'(done), 1);
            e.prod = 8'd63;
            e.cyc  = cyc + 1 + exp_lat(4'd9);
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            wait_done();
        end
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-operation
        issue(4'd9, 4'd11, 8'd99);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_product", 64'(product), 0);
        sb.delete();
        last_prod = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(4'd2, 4'd3, 8'd6);
        wait_done();

`ifdef SEQ_MUL_EARLY_TERM_EN
        issue(4'd13, 4'd0, 8'd0);
        wait_done();
        issue(4'd13, 4'd2, 8'd26);
        wait_done();
        issue(4'd13, 4'd8, 8'd104);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential unsigned multiplier using shift-and-add, one multiplier bit per clock.
- Generalises the team's fixed 2-bit combinational multiplier to WIDTH bits.
- Adds a start/busy/done handshake, so wide products cost WIDTH cycles instead of a WIDTH×WIDTH array.
- Used wherever lab datapaths need an area-cheap multiply with a registered result.

Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at posedge, accepted only when state != RUN
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; product valid
- product  output  2*WIDTH  registered result; held until next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc/mcand/mplr/count = 0.
  - Reset mid-RUN aborts the operation; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge k:
  - mcand <= {WIDTH'b0, a}, mplr <= b, acc <= 0, count <= 0.
  - state <= RUN; done <= 0.
- RUN, each edge:
  - if mplr[0], acc <= acc + mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
- RUN exit: on the edge performing iteration count==WIDTH-1:
  - product <= final accumulated value (including this iteration's add); state <= DONE; done <= 1.
- DONE lasts one cycle:
  - without start: state <= IDLE, done <= 0.
  - with start: accepted (back-to-back), as from IDLE.
- Latency: start accepted at edge k → done high between edges k+WIDTH and k+WIDTH+1. Throughput: one result per WIDTH+1 cycles.
- busy=1 exactly while state==RUN (edges k+1 through k+WIDTH window).
- start while busy: ignored. Operand registers are not disturbed and product is not changed.
- a, b are don't-care except at the accepting edge.
- product changes only on the edge asserting done; otherwise holds.
- Boundary cases:
  - a=0 or b=0 still takes WIDTH cycles (unless the optional feature is enabled) and yields 0.
  - Max operands: (2^WIDTH-1)^2 fits in 2*WIDTH bits.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined: in RUN, if the next mplr value is 0 after the current iteration, that edge writes product and enters DONE.
  - Latency = 1 + index of highest set bit of b; minimum 1 cycle for b=0 or b=1.
  - Results are identical to non-early-terminated operation.
- Undefined: fixed WIDTH-cycle latency regardless of operands.

Decomposition:
- Package seq_mul_pkg:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam helper for CNT_W.
- One natural sub-module: seq_mul_datapath, holding the acc/mcand/mplr registers and adder, controlled by load/step enables.
- Top holds the FSM, counter and output registers.

Test Plan:
- WIDTH=4, reset released, a=3, b=3, start 1 cycle → done exactly 4 cycles after the accepting edge, product=9, busy high for those 4 cycles.
- WIDTH=4, exhaustive a,b ∈ 0..15 (256 ops) against a*b reference; each result checked at the done pulse, product stable until the next done.
- a=15, b=15 → product=225. Then start pulsed again during busy with a=2, b=2 → ignored; result still 225, one done pulse only.
- Back-to-back: start held high across the DONE cycle with a=5, b=6 then a=7, b=9 → products 30 then 63, done pulses WIDTH+1 cycles apart.
- Start a=9, b=11; assert rst_n=0 two cycles later (async, between edges) → busy, done, product = 0 immediately. No done after release; next op a=2, b=3 → 6.
- With SEQ_MUL_EARLY_TERM_EN:
  - a=13, b=0 → done 1 cycle after accept, product=0.
  - a=13, b=2 → done after 2 cycles, product=26.
  - a=13, b=8 → done after 4 cycles, product=104.
